// File: rtl/decode_pkg.sv
// Shared decode definitions: execution-unit classes, per-unit operation codes,
// RV32I major opcodes and immediate formats. Also used by the execute stage.
package decode_pkg;

  localparam int TAG_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    XU_NOP       = 3'd0,
    XU_ALU       = 3'd1,
    XU_LUI_AUIPC = 3'd2,
    XU_BRANCH    = 3'd3,
    XU_JUMP      = 3'd4,
    XU_LOAD      = 3'd5,
    XU_STORE     = 3'd6
  } xu_t;

  // op is interpreted relative to xu_sel; ALU ops get the enum, other units reuse 4-bit codes.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } op_t;

  localparam logic [3:0] BR_BEQ  = 4'd0, BR_BNE  = 4'd1, BR_BLT   = 4'd4;
  localparam logic [3:0] BR_BGE  = 4'd5, BR_BLTU = 4'd6, BR_BGEU  = 4'd7;
  localparam logic [3:0] LD_LB   = 4'd0, LD_LH   = 4'd1, LD_LW    = 4'd2;
  localparam logic [3:0] LD_LBU  = 4'd4, LD_LHU  = 4'd5;
  localparam logic [3:0] ST_SB   = 4'd0, ST_SH   = 4'd1, ST_SW    = 4'd2;
  localparam logic [3:0] JMP_JAL = 4'd0, JMP_JALR = 4'd1;
  localparam logic [3:0] U_LUI   = 4'd0, U_AUIPC = 4'd1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  function automatic op_t alu_op(input logic [2:0] funct3, input logic alt);
    op_t r;
    case (funct3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate extraction; the sign always comes from instruction[31].
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instruction,
  input  fmt_t        fmt,
  output logic [31:0] imm
);

  // Assemble the immediate for the selected encoding format
  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I:   imm = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S:   imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B:   imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      FMT_U:   imm = {instruction[31:12], 12'd0};
      FMT_J:   imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: tracks the current fetch tag, squashes wrong-path instructions
// and registers a fully decoded RV32I operation for execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter int          TAG_W     = TAG_W_DEFAULT,
  parameter int unsigned START_TAG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [31:0]      NPC_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             jump_taken,
  output logic [31:0]      NPC_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [2:0]       xu_sel,
  output logic [3:0]       op,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [31:0]      imm,
  output logic             valid,
  output logic             illegal
);

  logic [TAG_W-1:0] curr_tag_q, curr_tag_d, tag_q, tag_d;
  logic [31:0]      npc_q, npc_d, imm_q, imm_d, imm_s;
  xu_t              xu_q, xu_d, xu_s;
  logic [3:0]       op_q, op_d, op_s;
  logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic             valid_q, valid_d, illegal_q, illegal_d;
  logic [6:0]       opcode_s, f7_s;
  logic [2:0]       f3_s;
  fmt_t             fmt_s;
  logic             live_s, ill_s, keep_rd_s, keep_rs1_s, keep_rs2_s;

  imm_gen u_imm_gen (
    .instruction (instruction),
    .fmt         (fmt_s),
    .imm         (imm_s)
  );

  // Classify the incoming word and work out which register fields it really uses
  always_comb begin
    opcode_s   = instruction[6:0];
    f3_s       = instruction[14:12];
    f7_s       = instruction[31:25];
    live_s     = (tag_in == curr_tag_q) && !jump_taken;
    xu_s       = XU_NOP;
    op_s       = 4'd0;
    fmt_s      = FMT_R;
    ill_s      = 1'b0;
    keep_rd_s  = 1'b1;
    keep_rs1_s = 1'b1;
    keep_rs2_s = 1'b1;
    case (opcode_s)
      OP_R: begin
        xu_s  = XU_ALU;
        op_s  = alu_op(f3_s, f7_s[5]);
        ill_s = !((f7_s == 7'b0000000) ||
                  ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
      end
      OP_I: begin
        xu_s = XU_ALU; fmt_s = FMT_I; keep_rs2_s = 1'b0;
        // Only the shift-right encoding treats funct7[5] as an opcode bit
        op_s  = alu_op(f3_s, (f3_s == 3'b101) && f7_s[5]);
        ill_s = ((f3_s == 3'b001) && (f7_s != 7'b0000000)) ||
                ((f3_s == 3'b101) && (f7_s != 7'b0000000) && (f7_s != 7'b0100000));
      end
      OP_LOAD: begin
        xu_s = XU_LOAD; fmt_s = FMT_I; keep_rs2_s = 1'b0;
        op_s  = {1'b0, f3_s};
        ill_s = (f3_s == 3'b011) || (f3_s[2:1] == 2'b11);
      end
      OP_STORE: begin
        xu_s = XU_STORE; fmt_s = FMT_S; keep_rd_s = 1'b0;
        op_s  = {1'b0, f3_s};
        ill_s = f3_s[2] || (f3_s == 3'b011);
      end
      OP_BRANCH: begin
        xu_s = XU_BRANCH; fmt_s = FMT_B; keep_rd_s = 1'b0;
        op_s  = {1'b0, f3_s};
        ill_s = (f3_s[2:1] == 2'b01);
      end
      OP_JAL: begin
        xu_s = XU_JUMP; fmt_s = FMT_J; op_s = JMP_JAL;
        keep_rs1_s = 1'b0; keep_rs2_s = 1'b0;
      end
      OP_JALR: begin
        xu_s = XU_JUMP; fmt_s = FMT_I; op_s = JMP_JALR; keep_rs2_s = 1'b0;
        ill_s = (f3_s != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        xu_s = XU_LUI_AUIPC; fmt_s = FMT_U;
        op_s = (opcode_s == OP_LUI) ? U_LUI : U_AUIPC;
        keep_rs1_s = 1'b0; keep_rs2_s = 1'b0;
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Next-state values: bubbles and illegal words carry no operands
  always_comb begin
    curr_tag_d = jump_taken ? curr_tag_q + TAG_W'(1) : curr_tag_q;
    tag_d      = tag_in;
    npc_d      = NPC_in;
    valid_d    = 1'b0;
    illegal_d  = 1'b0;
    xu_d       = XU_NOP;
    op_d       = 4'd0;
    rd_d       = 5'd0;
    rs1_d      = 5'd0;
    rs2_d      = 5'd0;
    imm_d      = 32'd0;
    if (live_s && ill_s) begin
      valid_d   = 1'b1;
      illegal_d = 1'b1;
    end else if (live_s) begin
      valid_d = 1'b1;
      xu_d    = xu_s;
      op_d    = op_s;
      rd_d    = keep_rd_s  ? instruction[11:7]  : 5'd0;
      rs1_d   = keep_rs1_s ? instruction[19:15] : 5'd0;
      rs2_d   = keep_rs2_s ? instruction[24:20] : 5'd0;
      imm_d   = imm_s;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register and current-tag tracker
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curr_tag_q <= TAG_W'(START_TAG);
      tag_q      <= '0;
      npc_q      <= 32'd0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      xu_q       <= XU_NOP;
      op_q       <= 4'd0;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      imm_q      <= 32'd0;
    end else begin
      curr_tag_q <= curr_tag_d;
      tag_q      <= tag_d;
      npc_q      <= npc_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      xu_q       <= xu_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
    end
  end

  assign NPC_out = npc_q;
  assign tag_out = tag_q;
  assign xu_sel  = xu_q;
  assign op      = op_q;
  assign rd      = rd_q;
  assign rs1     = rs1_q;
  assign rs2     = rs2_q;
  assign imm     = imm_q;
  assign valid   = valid_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage against an arithmetic reference decoder.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, NPC_in, NPC_out, imm;
  logic [3:0]  tag_in, tag_out, op;
  logic        jump_taken, valid, illegal;
  logic [2:0]  xu_sel;
  logic [4:0]  rd, rs1, rs2;

  int checks = 0;
  int failures = 0;
  int m_tag = 0;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [2:0]  xu;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } exp_t;

  logic [3:0] alu_tab [0:7] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  logic [3:0] ld_tab  [0:7] = '{LD_LB, LD_LH, LD_LW, 4'd0, LD_LBU, LD_LHU, 4'd0, 4'd0};
  logic [3:0] st_tab  [0:7] = '{ST_SB, ST_SH, ST_SW, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] br_tab  [0:7] = '{BR_BEQ, BR_BNE, 4'd0, 4'd0, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
  logic [6:0] opcs    [0:8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  decode_stage #(.TAG_W(4), .START_TAG(0)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .NPC_in(NPC_in),
    .tag_in(tag_in), .jump_taken(jump_taken), .NPC_out(NPC_out), .tag_out(tag_out),
    .xu_sel(xu_sel), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .valid(valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decode of a live word, using field arithmetic rather than bit slicing
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t        e;
    int unsigned u, opc, f3, f7, rdn, r1, r2;
    int          s;
    logic [31:0] iimm, simm, bimm, uimm, jimm;
    logic        ok;
    u = w; s = int'(w);
    opc = u % 128; f3 = (u / 4096) % 8; f7 = u / 33554432;
    rdn = (u / 128) % 32; r1 = (u / 32768) % 32; r2 = (u / 1048576) % 32;
    iimm = s >>> 20;
    simm = (s >>> 25) * 32 + int'(rdn);
    bimm = (s >>> 31) * 4096 + int'((u / 128) % 2) * 2048 + int'(f7 % 64) * 32 + int'((u / 256) % 16) * 2;
    uimm = u - (u % 4096);
    jimm = (s >>> 31) * 1048576 + int'((u / 4096) % 256) * 4096 + int'((u / 1048576) % 2) * 2048
           + int'((u / 2097152) % 1024) * 2;
    e = '0; e.valid = 1'b1; e.rd = rdn[4:0]; e.rs1 = r1[4:0]; e.rs2 = r2[4:0]; ok = 1'b1;
    case (opc)
      32'h33: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        e.xu = XU_ALU; e.op = alu_tab[f3];
        if (f7 == 32) e.op = (f3 == 0) ? 4'(ALU_SUB) : 4'(ALU_SRA);
      end
      32'h13: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
        e.xu = XU_ALU; e.op = (f3 == 5 && f7 == 32) ? 4'(ALU_SRA) : alu_tab[f3];
        e.rs2 = 5'd0; e.imm = iimm;
      end
      32'h03: begin
        ok = (f3 != 3 && f3 != 6 && f3 != 7);
        e.xu = XU_LOAD; e.op = ld_tab[f3]; e.rs2 = 5'd0; e.imm = iimm;
      end
      32'h23: begin
        ok = (f3 < 3); e.xu = XU_STORE; e.op = st_tab[f3]; e.rd = 5'd0; e.imm = simm;
      end
      32'h63: begin
        ok = (f3 != 2 && f3 != 3); e.xu = XU_BRANCH; e.op = br_tab[f3]; e.rd = 5'd0; e.imm = bimm;
      end
      32'h6F: begin
        e.xu = XU_JUMP; e.op = JMP_JAL; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = jimm;
      end
      32'h67: begin
        ok = (f3 == 0); e.xu = XU_JUMP; e.op = JMP_JALR; e.rs2 = 5'd0; e.imm = iimm;
      end
      32'h37, 32'h17: begin
        e.xu = XU_LUI_AUIPC; e.op = (opc == 32'h37) ? U_LUI : U_AUIPC;
        e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = uimm;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0; e.valid = 1'b1; e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Drive one instruction, clock it in and compare every output against the model
  task automatic step(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] tg, input logic jt);
    exp_t e;
    instruction = w; NPC_in = pc; tag_in = tg; jump_taken = jt;
    @(posedge clk); #1;
    e = (int'(tg) == m_tag && !jt) ? ref_decode(w) : '0;
    if (jt) m_tag = (m_tag + 1) % 16;
    chk("valid", valid, e.valid);
    chk("illegal", illegal, e.illegal);
    chk("xu_sel", xu_sel, e.xu);
    chk("op", op, e.op);
    chk("rd", rd, e.rd);
    chk("rs1", rs1, e.rs1);
    chk("rs2", rs2, e.rs2);
    chk("imm", imm, e.imm);
    chk("npc_out", NPC_out, pc);
    chk("tag_out", tag_out, tg);
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  tg;
    reset = 1'b0; instruction = 32'd0; NPC_in = 32'd0; tag_in = 4'd0; jump_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_xu", xu_sel, XU_NOP);
    chk("rst_imm", imm, 32'd0);
    chk("rst_npc", NPC_out, 32'd0);
    chk("rst_illegal", illegal, 1'b0);
    reset = 1'b1;

    step(32'h00510093, 32'h100, 4'd0, 1'b0);
    chk("addi_valid", valid, 1'b1); chk("addi_xu", xu_sel, XU_ALU); chk("addi_op", op, ALU_ADD);
    chk("addi_rd", rd, 5'd1); chk("addi_rs1", rs1, 5'd2); chk("addi_imm", imm, 32'h5);
    step(32'h00000013, 32'h104, 4'd0, 1'b0);
    chk("nop_xu", xu_sel, XU_ALU); chk("nop_rd", rd, 5'd0);
    step(32'hFE000EE3, 32'h108, 4'd0, 1'b0);
    chk("beq_xu", xu_sel, XU_BRANCH); chk("beq_op", op, BR_BEQ);
    chk("beq_rd", rd, 5'd0); chk("beq_imm", imm, 32'hFFFFFFFC);
    step(32'h123452B7, 32'h10C, 4'd0, 1'b0);
    chk("lui_xu", xu_sel, XU_LUI_AUIPC); chk("lui_op", op, U_LUI);
    chk("lui_rd", rd, 5'd5); chk("lui_rs1", rs1, 5'd0); chk("lui_imm", imm, 32'h12345000);

    step(32'h00510093, 32'h110, 4'd0, 1'b1);
    chk("sq_same_cycle", valid, 1'b0);
    step(32'h00510093, 32'h114, 4'd0, 1'b0);
    chk("sq_old_tag", valid, 1'b0);
    step(32'h00510093, 32'h118, 4'd1, 1'b0);
    chk("sq_new_tag", valid, 1'b1);

    for (int i = 0; i < 14; i++) step(32'h00510093, 32'h200 + 32'(i * 4), 4'(i), 1'b1);
    step(32'h00510093, 32'h300, 4'd0, 1'b0);
    chk("wrap_no_false", valid, 1'b0);
    step(32'h00510093, 32'h304, 4'd15, 1'b1);
    step(32'h00510093, 32'h308, 4'd0, 1'b0);
    chk("wrap_live", valid, 1'b1);
    step(32'h0000007F, 32'h30C, 4'd0, 1'b0);
    chk("ill_flag", illegal, 1'b1); chk("ill_valid", valid, 1'b1); chk("ill_xu", xu_sel, XU_NOP);

    step(32'h00510093, 32'h310, 4'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", valid, 1'b0); chk("async_npc", NPC_out, 32'd0);
    chk("async_xu", xu_sel, XU_NOP); chk("async_imm", imm, 32'd0);
    m_tag = 0;
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) w[6:0] = opcs[k];
      if ($urandom_range(0, 1) == 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      tg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(m_tag);
      step(w, $urandom, tg, ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch unit.
- Consumes the instruction word returned by memory, plus the PC (NPC) and 4-bit instruction tag that travel with it.
- Keeps its own copy of the current tag and squashes wrong-path instructions, which become bubbles. Produces a registered, fully decoded operation for the operand-fetch/execute stage.
- Decoded fields: class, opcode, register addresses, sign-extended immediate.

Parameters:
TAG_W, 4, width of instruction tag; must equal fetch tag width
START_TAG, 0, reset value of the internal current tag; must equal the fetch reset tag

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
instruction  input  32  instruction word for the address fetch issued earlier
NPC_in  input  32  PC of that instruction
tag_in  input  TAG_W  tag of that instruction
jump_taken  input  1  execute stage redirects the PC this cycle (same event that makes fetch bump its tag)
NPC_out  output  32  registered PC of decoded instruction
tag_out  output  TAG_W  registered tag
xu_sel  output  3  execution-unit class: NOP, ALU, LUI_AUIPC, BRANCH, JUMP, LOAD, STORE
op  output  4  unit-specific operation (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ..BGEU, LB..LHU, SB..SW, JAL, JALR, LUI, AUIPC)
rd, rs1, rs2  output  5 each  register addresses
imm  output  32  sign-extended immediate
valid  output  1  1 = real instruction, 0 = bubble
illegal  output  1  opcode or funct not in RV32I base subset

Behaviour:
- Reset (reset=0, asynchronous):
  - curr_tag=START_TAG.
  - All outputs 0; xu_sel=NOP, valid=0, illegal=0.
- Latency: single stage. Inputs sampled on posedge clk; all outputs registered and updated on the same edge.
- Tag tracking:
  - curr_tag increments modulo 2^TAG_W on every posedge where jump_taken=1.
  - Wrap 15 -> 0 is legal and must not cause false matches.
- Squash rule, evaluated with curr_tag before that edge's increment:
  - Instruction is live iff tag_in==curr_tag and jump_taken==0.
  - If jump_taken=1, the instruction at the input is squashed in that same cycle.
  - Non-live instruction: valid=0, xu_sel=NOP, op=0, rd=rs1=rs2=0, imm=0, illegal=0. NPC_out and tag_out still pass through (debug).
- Live-instruction decode, by opcode[6:0]:
  - 0110011 R-type ALU: funct7[5] selects SUB/SRA.
  - 0010011 I-type ALU: SRAI when funct7[5]=1 and funct3=101.
  - 0000011 LOAD, 0100011 STORE, 1100011 BRANCH.
  - 1101111 JAL, 1100111 JALR.
  - 0110111 LUI, 0010111 AUIPC.
  - Any other opcode, or a reserved funct3/funct7 combination: illegal=1, valid=1, xu_sel=NOP (execute traps or ignores).
  - instruction==32'h00000013 (canonical NOP) decodes as ALU ADD x0,x0,0. No special casing.
- Register fields:
  - rd is forced to 0 for STORE and BRANCH.
  - rs2 is forced to 0 for I/U/J formats.
  - rs1 is forced to 0 for LUI, AUIPC and JAL.
- Immediate, sign bit is always instruction[31]:
  - I: imm[11:0].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type: imm=0.
- Consecutive jump_taken cycles: each increments curr_tag, and every instruction arriving with an old tag is dropped.
- Reset mid-stream: outputs clear immediately (asynchronously), independent of clk.

Decomposition:
- Package decode_pkg holds:
  - enum xu_t (NOP, ALU, LUI_AUIPC, BRANCH, JUMP, LOAD, STORE)
  - enum op_t
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - TAG_W default
- The package is shared with the execute stage.
- Sub-module imm_gen: purely combinational; inputs instruction and format; output 32-bit imm.
- Tag compare and classification stay in decode_stage.

Test Plan:
- Reset: hold reset=0 for 3 cycles with clk running, then release -> all outputs 0, valid=0; first live instruction is accepted with tag_in=0.
- ADDI x1,x2,5:
  - Stimulus: instruction=0x00510093, tag_in=0, NPC_in=0x100.
  - Next edge: valid=1, xu_sel=ALU, op=ADD, rd=1, rs1=2, rs2=0, imm=0x00000005, NPC_out=0x100.
- BEQ x0,x0,-4:
  - Stimulus: instruction=0xFE000EE3.
  - Expect: xu_sel=BRANCH, op=BEQ, rd=0, imm=0xFFFFFFFC.
- LUI x5,0x12345:
  - Stimulus: instruction=0x123452B7.
  - Expect: xu_sel=LUI_AUIPC, op=LUI, rd=5, rs1=0, imm=0x12345000.
- Squash:
  - Pulse jump_taken=1 while tag_in=0 -> that instruction gives valid=0.
  - Next instruction with tag_in=0 -> valid=0.
  - Instruction with tag_in=1 -> valid=1.
- Wrap and illegal:
  - Apply 16 jump_taken pulses -> tag_in=0 is live again.
  - instruction=0x0000007F -> illegal=1, xu_sel=NOP.
